spi_bus_arbiter: RTL

//  Shares the single CC2420 SPI engine between four requesters: radio init, RX FIFO

---
 rtl/spi_bus_arbiter_if.sv | 21 ++
 rtl/spi_bus_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Request/grant bundle between the radio control requesters and the shared SPI engine arbiter.
interface spi_bus_arbiter_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;
   logic       init_ok;
   logic [1:0] state;

   modport slave (
      input  req, done,
      output grant, sel, busy, timeout, init_ok, state
   );

   modport master (
      output req, done,
      input  grant, sel, busy, timeout, init_ok, state
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the single CC2420 SPI engine between Init/Rx/ChannelChange/Tx requesters,
// enforcing a CSn gap after each release and a watchdog on hung transfers.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | no owner; picks Init first, else round-robin Rx/Ch/Tx
//  GRANT | one requester owns the engine; watchdog running
//  GAP   | CSn high time after release; requests ignored
module spi_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMEOUT_W      = 12,
   parameter int GAP_CYCLES     = 2
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   spi_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = '1;
   localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t               state_q, state_d;
   logic [3:0]           grant_q, grant_d;
   logic [1:0]           sel_q, sel_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;
   logic                 init_ok_q, init_ok_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic [GAP_W-1:0]     gap_q, gap_d;

   logic [3:0] elig;
   logic       rr_found;
   logic [1:0] rr_idx;
   logic [2:0] cand;
   logic       release_now;

   // Rx/Ch/Tx stay masked until the radio has completed an Init transaction.
   assign elig = {bus.req[3:1] & {3{init_ok_q}}, bus.req[0]};

   // rr_ptr_q holds the first index to try, always within 1..3.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = 2'd1;
      cand     = 3'd0;
      for (int i = 0; i < 3; i++) begin
         cand = {1'b0, rr_ptr_q} + 3'(i);
         if (cand > 3'd3) cand = cand - 3'd3;
         if (!rr_found && elig[cand[1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      timeout_d   = 1'b0;
      init_ok_d   = init_ok_q;
      rr_ptr_d    = rr_ptr_q;
      wdog_d      = wdog_q;
      gap_d       = gap_q;
      release_now = 1'b0;

      case (state_q)
         IDLE: begin
            if (elig[0]) begin
               state_d = GRANT;
               grant_d = 4'b0001;
               sel_d   = 2'd0;
               wdog_d  = '0;
            end else if (rr_found) begin
               state_d  = GRANT;
               grant_d  = 4'b0001 << rr_idx;
               sel_d    = rr_idx;
               wdog_d   = '0;
               rr_ptr_d = (rr_idx == 2'd3) ? 2'd1 : rr_idx + 2'd1;
            end
         end
         GRANT: begin
            // Done outranks both an abort and a simultaneous watchdog expiry.
            if (bus.done) begin
               release_now = 1'b1;
               if (grant_q[0]) init_ok_d = 1'b1;
            end else if (!bus.req[sel_q]) begin
               release_now = 1'b1;
            end else if (wdog_q == WDOG_LAST) begin
               release_now = 1'b1;
               timeout_d   = 1'b1;
            end else if (wdog_q != WDOG_MAX) begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (release_now) begin
         grant_d = '0;
         if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
         end else begin
            state_d = IDLE;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         init_ok_q <= 1'b0;
         rr_ptr_q  <= 2'd1;
         wdog_q    <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         init_ok_q <= init_ok_d;
         rr_ptr_q  <= rr_ptr_d;
         wdog_q    <= wdog_d;
         gap_q     <= gap_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;
   assign bus.init_ok = init_ok_q;
   assign bus.state   = state_q;

endmodule
